clint_timer: RTL and testbench
==============================

// Module: clint_timer
// PURPOSE
//  Core-local interruptor: memory-mapped mtime/mtimecmp/msip source of the MTI and MSI interrupt
//  lines consumed by the CSR unit (mip.MTIP/MSIP, bits 7/3). Wishbone classic slave on the data bus;
//  interrupt outputs wired straight to the core's CSR interrupt inputs.
// PARAMETERS
//  DATA_SIZE  32  bus width, 32 or 64; 64-bit registers are split into lo/hi words when 32
//  PRESCALE   1   mtime increments once every PRESCALE clock cycles (>=1)
// PORTS
//  clock      in   1            system clock
//  reset_n    in   1            asynchronous, active-low reset
//  wb_cyc_i   in   1            bus cycle valid
//  wb_stb_i   in   1            strobe
//  wb_we_i    in   1            1 = write
//  wb_addr_i  in   16           byte offset inside CLINT
//  wb_sel_i   in   DATA_SIZE/8  byte enables (writes only)
//  wb_dat_i   in   DATA_SIZE    write data
//  wb_dat_o   out  DATA_SIZE    read data, valid while wb_ack_o=1
//  wb_ack_o   out  1            transfer acknowledge
//  msip_o     out  1            machine software interrupt (msip[0])
//  mtip_o     out  1            machine timer interrupt
//  ssip_o     out  1            supervisor software interrupt (CLINT_SSIP_EN only)
//  mtime_o    out  64           current mtime (for time CSR shadow)
// BEHAVIOUR
//  Map: 0x0000 msip (bit0 only, rest RAZ/WI); 0x4000 mtimecmp; 0xBFF8 mtime. 32-bit bus: +4 = hi word.
//   64-bit bus: addr[2:0] must be 0. Misaligned/unmapped: read 0, write ignored, still acked.
//  Reset: mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, msip=0, ssip=0, prescale cnt=0, wb_ack_o=0,
//   wb_dat_o=0, mtip_o=0, FSM=IDLE.
//  Bus FSM: IDLE --(cyc&stb)--> ACK (capture addr/we/sel/data; read data registered) --> IDLE.
//   wb_ack_o high exactly one cycle, one cycle after the request; at most one ack per two cycles.
//   Write commits on the clock edge ending the ACK cycle, honoring wb_sel_i per byte.
//   cyc or stb dropped during ACK: ack still pulses once, write still commits (no abort).
//  Tick: counter 0..PRESCALE-1; tick when count==PRESCALE-1, then wraps to 0. PRESCALE=1: every cycle.
//  mtime: +1 on tick, 64-bit wrap FFFF..FF -> 0. Bus write to any mtime byte in the same cycle as a
//   tick: written bytes take write data, unwritten bytes keep the pre-increment value (write wins, no
//   carry into written bytes). Read returns value before that cycle's increment.
//  mtip_o: registered (mtime >= mtimecmp), unsigned 64-bit compare, one-cycle latency after the
//   update of either operand; deasserts same latency after mtimecmp raised above mtime.
//  msip_o = msip[0] register, changes on the commit edge.
//  Reset asserted mid-transfer: ack suppressed, write dropped, all state to reset values.
// CONFIGURATION
//  CLINT_SSIP_EN defined: register at 0x0004 (setssip, bit0) drives ssip_o (SSI, mip bit 1), write
//   semantics as msip. Undefined: 0x0004 behaves unmapped, ssip_o tied 0.
// STRUCTURE
//  Shared package csr_pkg gains: clint_addr_t enum (Msip=16'h0000, Ssip=16'h0004,
//   Mtimecmp=16'h4000, Mtime=16'hBFF8) and MtimecmpReset constant; interrupt_t codes reused for
//   bench checking of mip bits. Sub-module clint_tick_gen: PRESCALE counter producing tick pulse.
// TESTING
//  Reset release, no bus traffic, PRESCALE=1 -> mtime_o=N after N cycles; mtip_o=0, msip_o=0.
//  Write mtimecmp=0x20 (lo, then hi=0) -> mtip_o rises 1 cycle after mtime_o reaches 0x20; write
//   mtimecmp=0x1000 -> mtip_o falls 1 cycle after commit.
//  Write msip=0xFFFF_FFFF -> msip_o=1, read msip returns 0x1; write 0 -> msip_o=0.
//  Write mtime lo=0xFFFF_FFFF, hi=0 on tick cycle -> lo holds written value then wraps, hi becomes 1.
//  PRESCALE=4 -> mtime increments every 4th cycle; read at 0x1234 returns 0 with single ack pulse.
//  Assert reset_n=0 during ACK of a mtimecmp write -> no ack, mtimecmp=all ones after release;
//   with CLINT_SSIP_EN, write 0x0004=1 -> ssip_o=1, without it -> ssip_o=0, read 0.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared CSR/CLINT definitions: interrupt cause codes, CLINT register map, bus FSM states
// and the address decode / byte-merge helpers used by the CLINT.
package csr_pkg;

    typedef enum logic [3:0] {
        IntSsi = 4'd1,
        IntMsi = 4'd3,
        IntSti = 4'd5,
        IntMti = 4'd7,
        IntSei = 4'd9,
        IntMei = 4'd11
    } interrupt_t;

    typedef enum logic [15:0] {
        Msip     = 16'h0000,
        Ssip     = 16'h0004,
        Mtimecmp = 16'h4000,
        Mtime    = 16'hBFF8
    } clint_addr_t;

    localparam logic [63:0] MtimecmpReset = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic {
        StIdle,
        StAck
    } clint_state_t;

    typedef struct packed {
        logic msip;
        logic mtimecmp;
        logic mtime;
        logic hi;
    } clint_dec_t;

    // Registers are viewed as 64-bit doublewords; on a 32-bit bus addr[2] picks the hi word.
    // The msip doubleword carries setssip in its upper word, so 0x0004 lands on bit 32.
    function automatic clint_dec_t clint_decode(input logic [15:0] addr, input logic wide);
        clint_dec_t  dec;
        logic        aligned;
        logic [15:0] base;
        aligned      = wide ? (addr[2:0] == 3'b000) : (addr[1:0] == 2'b00);
        base         = {addr[15:3], 3'b000};
        dec.msip     = aligned && (base == Msip);
        dec.mtimecmp = aligned && (base == Mtimecmp);
        dec.mtime    = aligned && (base == Mtime);
        dec.hi       = !wide && addr[2];
        return dec;
    endfunction

    function automatic logic [63:0] byte_merge(input logic [63:0] old, input logic [63:0] data,
                                               input logic [7:0] mask);
        logic [63:0] res;
        for (int i = 0; i < 8; i++) begin
            res[8*i +: 8] = mask[i] ? data[8*i +: 8] : old[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/clint_tick_gen.sv
// Prescaler for the CLINT time base: pulses tick once every PRESCALE clock cycles.
module clint_tick_gen #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clock,
    input  logic reset_n,
    output logic tick
);

    localparam int unsigned CntW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(PRESCALE - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // With PRESCALE=1 the counter is pinned at zero and tick stays high.
    always_comb begin
        tick  = (cnt_q == CntMax);
        cnt_d = tick ? '0 : cnt_q + CntW'(1);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/clint_timer.sv
// Core-local interruptor: Wishbone-mapped msip/mtimecmp/mtime producing MSI/MTI lines.
// Define CLINT_SSIP_EN to add the setssip register at 0x0004 driving ssip_o.
module clint_timer
    import csr_pkg::*;
#(
    parameter int unsigned DATA_SIZE = 32,
    parameter int unsigned PRESCALE  = 1
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   wb_cyc_i,
    input  logic                   wb_stb_i,
    input  logic                   wb_we_i,
    input  logic [15:0]            wb_addr_i,
    input  logic [DATA_SIZE/8-1:0] wb_sel_i,
    input  logic [DATA_SIZE-1:0]   wb_dat_i,
    output logic [DATA_SIZE-1:0]   wb_dat_o,
    output logic                   wb_ack_o,
    output logic                   msip_o,
    output logic                   mtip_o,
    output logic                   ssip_o,
    output logic [63:0]            mtime_o
);

    localparam int unsigned SelW = DATA_SIZE / 8;
    localparam logic        Wide = (DATA_SIZE == 64);

    clint_state_t          state_q;
    logic [15:0]           addr_q;
    logic                  we_q;
    logic [SelW-1:0]       sel_q;
    logic [DATA_SIZE-1:0]  dat_q;
    logic                  ack_q;
    logic [DATA_SIZE-1:0]  rdata_q;

    logic                  msip_q, msip_d;
    logic                  mtip_q;
    logic [63:0]           mtime_q, mtime_d;
    logic [63:0]           mtimecmp_q, mtimecmp_d;
    logic                  ssip;

    logic                  tick;
    logic                  commit;
    clint_dec_t            dec_rd, dec_wr;
    logic [63:0]           rd_dw;
    logic [DATA_SIZE-1:0]  rd_word;
    logic [63:0]           wr_data;
    logic [7:0]            wr_mask;

    clint_tick_gen #(
        .PRESCALE(PRESCALE)
    ) u_tick_gen (
        .clock  (clock),
        .reset_n(reset_n),
        .tick   (tick)
    );

    assign dec_rd = clint_decode(wb_addr_i, Wide);
    assign dec_wr = clint_decode(addr_q, Wide);
    assign commit = (state_q == StAck) && we_q;

    always_comb begin
        rd_dw = '0;
        if (dec_rd.msip) begin
            rd_dw = {31'b0, ssip, 31'b0, msip_q};
        end else if (dec_rd.mtimecmp) begin
            rd_dw = mtimecmp_q;
        end else if (dec_rd.mtime) begin
            rd_dw = mtime_q;
        end
    end

    generate
        if (DATA_SIZE == 64) begin : g_bus64
            assign rd_word = rd_dw;
            assign wr_mask = sel_q;
            assign wr_data = dat_q;
        end else begin : g_bus32
            assign rd_word = dec_rd.hi ? rd_dw[63:32] : rd_dw[31:0];
            assign wr_mask = dec_wr.hi ? {sel_q, 4'b0000} : {4'b0000, sel_q};
            assign wr_data = {dat_q, dat_q};
        end
    endgenerate

    // A bus write to mtime replaces that cycle's increment: unwritten bytes keep the
    // pre-increment value and no carry reaches the written bytes.
    always_comb begin
        mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
        mtimecmp_d = mtimecmp_q;
        msip_d     = msip_q;
        if (commit) begin
            if (dec_wr.mtime && (wr_mask != 8'h00)) begin
                mtime_d = byte_merge(mtime_q, wr_data, wr_mask);
            end
            if (dec_wr.mtimecmp) begin
                mtimecmp_d = byte_merge(mtimecmp_q, wr_data, wr_mask);
            end
            if (dec_wr.msip && wr_mask[0]) begin
                msip_d = wr_data[0];
            end
        end
    end

`ifdef CLINT_SSIP_EN
    logic ssip_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ssip_q <= 1'b0;
        end else if (commit && dec_wr.msip && wr_mask[4]) begin
            ssip_q <= wr_data[32];
        end
    end

    assign ssip = ssip_q;
`else
    assign ssip = 1'b0;
`endif

    // Bus FSM plus timer state. Once a request is captured the ACK cycle always completes,
    // even if cyc/stb drop; only reset can cancel it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            we_q       <= 1'b0;
            sel_q      <= '0;
            dat_q      <= '0;
            ack_q      <= 1'b0;
            rdata_q    <= '0;
            msip_q     <= 1'b0;
            mtip_q     <= 1'b0;
            mtime_q    <= '0;
            mtimecmp_q <= MtimecmpReset;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            msip_q     <= msip_d;
            mtip_q     <= (mtime_q >= mtimecmp_q);
            case (state_q)
                StIdle: begin
                    ack_q <= 1'b0;
                    if (wb_cyc_i && wb_stb_i) begin
                        state_q <= StAck;
                        ack_q   <= 1'b1;
                        addr_q  <= wb_addr_i;
                        we_q    <= wb_we_i;
                        sel_q   <= wb_sel_i;
                        dat_q   <= wb_dat_i;
                        rdata_q <= wb_we_i ? '0 : rd_word;
                    end
                end
                StAck: begin
                    state_q <= StIdle;
                    ack_q   <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    ack_q   <= 1'b0;
                end
            endcase
        end
    end

    assign wb_ack_o = ack_q;
    assign wb_dat_o = rdata_q;
    assign msip_o   = msip_q;
    assign mtip_o   = mtip_q;
    assign ssip_o   = ssip;
    assign mtime_o  = mtime_q;

endmodule

// File: tb/tb_clint_timer.sv
// Bench for clint_timer: PRESCALE=1 and PRESCALE=4 instances, table-driven register accesses
// with a read-data scoreboard, plus hand sequences for timer, wrap and reset corner cases.
module tb_clint_timer;
    import csr_pkg::*;

`ifdef CLINT_SSIP_EN
    localparam logic SsipExp = 1'b1;
`else
    localparam logic SsipExp = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        cyc_a [2];
    logic        stb_a [2];
    logic        we_a  [2];
    logic [15:0] addr_a[2];
    logic [3:0]  sel_a [2];
    logic [31:0] wdat_a[2];
    logic [31:0] rdat  [2];
    logic        ack   [2];
    logic        msip  [2];
    logic        mtip  [2];
    logic        ssip  [2];
    logic [63:0] mt    [2];

    always #5 clock = ~clock;

    clint_timer #(.DATA_SIZE(32), .PRESCALE(1)) dut (
        .clock(clock), .reset_n(reset_n), .wb_cyc_i(cyc_a[0]), .wb_stb_i(stb_a[0]),
        .wb_we_i(we_a[0]), .wb_addr_i(addr_a[0]), .wb_sel_i(sel_a[0]), .wb_dat_i(wdat_a[0]),
        .wb_dat_o(rdat[0]), .wb_ack_o(ack[0]), .msip_o(msip[0]), .mtip_o(mtip[0]),
        .ssip_o(ssip[0]), .mtime_o(mt[0])
    );

    clint_timer #(.DATA_SIZE(32), .PRESCALE(4)) dut4 (
        .clock(clock), .reset_n(reset_n), .wb_cyc_i(cyc_a[1]), .wb_stb_i(stb_a[1]),
        .wb_we_i(we_a[1]), .wb_addr_i(addr_a[1]), .wb_sel_i(sel_a[1]), .wb_dat_i(wdat_a[1]),
        .wb_dat_o(rdat[1]), .wb_ack_o(ack[1]), .msip_o(msip[1]), .mtip_o(mtip[1]),
        .ssip_o(ssip[1]), .mtime_o(mt[1])
    );

    typedef struct packed {
        logic        is_read;
        logic [31:0] exp;
    } sb_t;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [31:0] exp_rd;
        logic        e_msip;
        logic        e_ssip;
    } vec_t;

    sb_t         sb0[$];
    sb_t         sb1[$];
    vec_t        tbl[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc_cnt = 0;
    int          n_ack[2];
    logic        prev_ack[2];
    logic [63:0] mdl_base = '0;
    int          mdl_ref = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] mip_vec(input logic m, input logic t, input logic s);
        logic [15:0] v;
        v = '0;
        v[int'(IntMsi)] = m;
        v[int'(IntMti)] = t;
        v[int'(IntSsi)] = s;
        return v;
    endfunction

    // Bench model of mtime (PRESCALE=1): value after edge c, from a known anchor.
    function automatic logic [63:0] model_at(input int c);
        return mdl_base + 64'(c - mdl_ref);
    endfunction

    task automatic bus(input int d, input logic w, input logic [15:0] a, input logic [31:0] dat,
                       input logic [3:0] s, input logic [31:0] exp, input bit use_model);
        sb_t         e;
        logic [63:0] m;
        @(posedge clock);
        #1;
        cyc_a[d] = 1'b1; stb_a[d] = 1'b1; we_a[d] = w;
        addr_a[d] = a; sel_a[d] = s; wdat_a[d] = dat;
        m = model_at(cyc_cnt);
        e.is_read = !w;
        e.exp = use_model ? (a[2] ? m[63:32] : m[31:0]) : exp;
        if (d == 0) sb0.push_back(e);
        else sb1.push_back(e);
        @(posedge clock);
        #1;
        cyc_a[d] = 1'b0; stb_a[d] = 1'b0; we_a[d] = 1'b0; sel_a[d] = '0; wdat_a[d] = '0;
        check($sformatf("ack_timing%0d", d), 64'(ack[d]), 64'd1);
        @(posedge clock);
        #1;
        check($sformatf("ack_end%0d", d), 64'(ack[d]), 64'd0);
    endtask

    task automatic add(input logic we, input logic [15:0] a, input logic [31:0] dat,
                       input logic [3:0] s, input logic [31:0] rd, input logic m, input logic ss);
        tbl.push_back('{we, a, dat, s, rd, m, ss});
    endtask

    initial begin
        forever begin
            @(posedge clock);
            cyc_cnt++;
        end
    end

    // Scoreboard: every ack pops one pending request; reads compare the returned data.
    initial begin
        sb_t e;
        for (int d = 0; d < 2; d++) begin
            n_ack[d] = 0;
            prev_ack[d] = 1'b0;
        end
        forever begin
            @(negedge clock);
            for (int d = 0; d < 2; d++) begin
                if (ack[d] === 1'b1) begin
                    n_ack[d]++;
                    check($sformatf("ack_single%0d", d), 64'(prev_ack[d]), 64'd0);
                    if ((d == 0 && sb0.size() == 0) || (d == 1 && sb1.size() == 0)) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL sb_underflow: dut%0d acked with no request pending", d);
                    end else begin
                        if (d == 0) e = sb0.pop_front();
                        else e = sb1.pop_front();
                        if (e.is_read) begin
                            check($sformatf("rdata%0d", d), 64'(rdat[d]), 64'(e.exp));
                        end
                    end
                end
                prev_ack[d] = ack[d];
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] tmp;
        logic [63:0] exp64;
        int          nb;
        bit          found;
        for (int d = 0; d < 2; d++) begin
            cyc_a[d] = 1'b0; stb_a[d] = 1'b0; we_a[d] = 1'b0;
            addr_a[d] = '0; sel_a[d] = '0; wdat_a[d] = '0;
        end

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        for (int d = 0; d < 2; d++) begin
            check("rst_mtime", mt[d], 64'd0);
            check("rst_mip", 64'(mip_vec(msip[d], mtip[d], ssip[d])), 64'd0);
            check("rst_ack", 64'(ack[d]), 64'd0);
            check("rst_dat", 64'(rdat[d]), 64'd0);
        end
        @(negedge clock);
        reset_n = 1'b1;

        // Free-running time base, PRESCALE=1 and PRESCALE=4
        for (int k = 1; k <= 24; k++) begin
            @(posedge clock);
            #1;
            check("mtime_p1", mt[0], 64'(k));
            check("mtime_p4", mt[1], 64'(k / 4));
        end

        // Register access table on the PRESCALE=1 instance
        add(1'b0, 16'h4000, 32'h0,         4'h0, 32'hFFFF_FFFF, 1'b0, 1'b0);
        add(1'b0, 16'h4004, 32'h0,         4'h0, 32'hFFFF_FFFF, 1'b0, 1'b0);
        add(1'b0, 16'h0000, 32'h0,         4'h0, 32'h0,         1'b0, 1'b0);
        add(1'b0, 16'hBFFC, 32'h0,         4'h0, 32'h0,         1'b0, 1'b0);
        add(1'b1, 16'h0000, 32'hFFFF_FFFF, 4'hF, 32'h0,         1'b1, 1'b0);
        add(1'b0, 16'h0000, 32'h0,         4'h0, 32'h1,         1'b1, 1'b0);
        add(1'b1, 16'h4000, 32'h1234_5678, 4'h3, 32'h0,         1'b1, 1'b0);
        add(1'b0, 16'h4000, 32'h0,         4'h0, 32'hFFFF_5678, 1'b1, 1'b0);
        add(1'b1, 16'h4004, 32'hA5A5_A5A5, 4'h8, 32'h0,         1'b1, 1'b0);
        add(1'b0, 16'h4004, 32'h0,         4'h0, 32'hA5FF_FFFF, 1'b1, 1'b0);
        add(1'b0, 16'h1234, 32'h0,         4'h0, 32'h0,         1'b1, 1'b0);
        add(1'b1, 16'h1234, 32'hDEAD_BEEF, 4'hF, 32'h0,         1'b1, 1'b0);
        add(1'b0, 16'h4002, 32'h0,         4'h0, 32'h0,         1'b1, 1'b0);
        add(1'b1, 16'h4001, 32'h0,         4'hF, 32'h0,         1'b1, 1'b0);
        add(1'b0, 16'h4000, 32'h0,         4'h0, 32'hFFFF_5678, 1'b1, 1'b0);
        add(1'b1, 16'h0000, 32'h0,         4'h1, 32'h0,         1'b0, 1'b0);
        add(1'b0, 16'h0000, 32'h0,         4'h0, 32'h0,         1'b0, 1'b0);
        add(1'b1, 16'h0000, 32'h1,         4'hE, 32'h0,         1'b0, 1'b0);
        add(1'b0, 16'h0000, 32'h0,         4'h0, 32'h0,         1'b0, 1'b0);
        add(1'b1, 16'h0004, 32'h1,         4'h1, 32'h0,         1'b0, SsipExp);
        add(1'b0, 16'h0004, 32'h0,         4'h0, 32'(SsipExp),  1'b0, SsipExp);
        add(1'b1, 16'h0000, 32'h1,         4'h1, 32'h0,         1'b1, SsipExp);
        for (int i = 0; i < tbl.size(); i++) begin
            bus(0, tbl[i].we, tbl[i].addr, tbl[i].dat, tbl[i].sel, tbl[i].exp_rd, 1'b0);
            check($sformatf("mip[%0d]", i), 64'(mip_vec(msip[0], mtip[0], ssip[0])),
                  64'(mip_vec(tbl[i].e_msip, 1'b0, tbl[i].e_ssip)));
        end

        // Unmapped read on PRESCALE=4 instance: data 0, exactly one ack
        nb = n_ack[1];
        bus(1, 1'b0, 16'h1234, 32'h0, 4'h0, 32'h0, 1'b0);
        repeat (3) @(posedge clock);
        #1;
        check("ack_count_p4", 64'(n_ack[1] - nb), 64'd1);

        // mtip rise/fall
        bus(0, 1'b1, 16'hBFF8, 32'h0, 4'hF, 32'h0, 1'b0);
        bus(0, 1'b1, 16'h4000, 32'h20, 4'hF, 32'h0, 1'b0);
        bus(0, 1'b1, 16'h4004, 32'h0, 4'hF, 32'h0, 1'b0);
        check("mtip_before", 64'(mtip[0]), 64'd0);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(posedge clock);
            #1;
            if (mt[0] == 64'h20) found = 1'b1;
        end
        check("mtime_reach_20", 64'(found), 64'd1);
        check("mtip_same_cycle", 64'(mtip[0]), 64'd0);
        @(posedge clock);
        #1;
        check("mtip_rise", 64'(mip_vec(msip[0], mtip[0], ssip[0])),
              64'(mip_vec(1'b1, 1'b1, SsipExp)));
        bus(0, 1'b1, 16'h4000, 32'h1000, 4'hF, 32'h0, 1'b0);
        check("mtip_hold", 64'(mtip[0]), 64'd1);
        @(posedge clock);
        #1;
        check("mtip_fall", 64'(mtip[0]), 64'd0);

        // mtime wrap of the lo word into hi
        bus(0, 1'b1, 16'hBFFC, 32'h0, 4'hF, 32'h0, 1'b0);
        bus(0, 1'b1, 16'hBFF8, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b0);
        check("wrap_written", mt[0], 64'h0000_0000_FFFF_FFFF);
        mdl_base = 64'h0000_0000_FFFF_FFFF;
        mdl_ref = cyc_cnt;
        @(posedge clock);
        #1;
        check("wrap_carry", mt[0], 64'h0000_0001_0000_0000);

        // Hi-word write on a tick cycle: lo keeps its pre-increment value
        bus(0, 1'b1, 16'hBFFC, 32'h7, 4'hF, 32'h0, 1'b0);
        tmp = model_at(cyc_cnt - 1);
        exp64 = {32'h7, tmp[31:0]};
        check("mtime_write_wins", mt[0], exp64);
        mdl_base = exp64;
        mdl_ref = cyc_cnt;
        bus(0, 1'b0, 16'hBFF8, 32'h0, 4'h0, 32'h0, 1'b1);
        bus(0, 1'b0, 16'hBFFC, 32'h0, 4'h0, 32'h0, 1'b1);
        check("mtime_model", mt[0], model_at(cyc_cnt));

        // Reset during the ACK cycle of a mtimecmp write
        @(posedge clock);
        #1;
        cyc_a[0] = 1'b1; stb_a[0] = 1'b1; we_a[0] = 1'b1;
        addr_a[0] = 16'h4000; wdat_a[0] = 32'h55; sel_a[0] = 4'hF;
        @(posedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        check("ack_suppressed", 64'(ack[0]), 64'd0);
        cyc_a[0] = 1'b0; stb_a[0] = 1'b0; we_a[0] = 1'b0; sel_a[0] = '0; wdat_a[0] = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("post_rst_mtime", mt[0], 64'd3);
        check("post_rst_mip", 64'(mip_vec(msip[0], mtip[0], ssip[0])), 64'd0);
        bus(0, 1'b0, 16'h4000, 32'h0, 4'h0, 32'hFFFF_FFFF, 1'b0);
        bus(0, 1'b0, 16'h4004, 32'h0, 4'h0, 32'hFFFF_FFFF, 1'b0);
        bus(0, 1'b0, 16'h0000, 32'h0, 4'h0, 32'h0, 1'b0);
        bus(0, 1'b0, 16'h0004, 32'h0, 4'h0, 32'h0, 1'b0);

        repeat (2) @(posedge clock);
        #1;
        check("sb_drain0", 64'(sb0.size()), 64'd0);
        check("sb_drain1", 64'(sb1.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
